// File: rtl/radix4_booth_mul_seq_if.sv
// Operand/result handshake bundle for the radix-4 Booth multiplier.
// master drives operands and out_ready, slave is the multiplier.
interface radix4_booth_mul_seq_if #(
  parameter int WIDTH = 16
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_o;
  logic               busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, out_o, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, out_o, busy
  );
endinterface

// File: rtl/radix4_booth_mul_seq.sv
// Iterative signed radix-4 Booth multiplier.
// One Booth digit of y is retired per clock through a single adder.
module radix4_booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  radix4_booth_mul_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int ND = WIDTH / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  logic [1:0]    state;
  logic [PW-1:0] xs;
  logic [WIDTH:0] yr;
  logic [PW-1:0] acc;
  logic [PW-1:0] out_q;
  logic [CW-1:0] cnt;
  logic [PW-1:0] term;
  logic [PW-1:0] sum;

  // xs is pre-shifted by 2*cnt and yr by -2*cnt, so the
  // current digit always sits in yr[2:0] and needs no barrel shift.
  always_comb begin
    term = '0;
    unique case (yr[2:0])
      3'b001, 3'b010: term = xs;
      3'b011:         term = xs << 1;
      3'b100:         term = -(xs << 1);
      3'b101, 3'b110: term = -xs;
      default:        term = '0;
    endcase
  end

  assign sum = acc + term;

  // Sequencer: accept in IDLE, accumulate in RUN, hold in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xs    <= '0;
      yr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xs    <= {{WIDTH{bus.x[WIDTH-1]}}, bus.x};
            yr    <= {bus.y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          xs  <= xs << 2;
          yr  <= yr >> 2;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_q <= sum;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_o     = out_q;
endmodule
